// File: rtl/flappy_pkg.sv
// Shared types, game geometry/physics constants and small arithmetic helpers
// for the flappy game sequencer.
package flappy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam logic [15:0]        BIRD_X     = 16'd160;
  localparam logic [15:0]        BIRD_H     = 16'd24;
  localparam logic [15:0]        START_Y    = 16'd200;
  localparam logic [15:0]        GROUND_Y   = 16'd440;
  localparam logic [15:0]        FLOOR_Y    = GROUND_Y - BIRD_H;
  localparam logic signed [7:0]  GRAVITY    = 8'sd1;
  localparam logic signed [7:0]  FLAP_VEL   = -8'sd8;
  localparam logic signed [7:0]  VMAX       = 8'sd10;
  localparam logic [15:0]        PIPE_SPEED = 16'd2;
  localparam logic [15:0]        PIPE_START = 16'd640;
  localparam logic [15:0]        GAP_MIN    = 16'd64;

  localparam logic [15:0]        LFSR_SEED  = 16'hACE1;
  localparam logic [15:0]        LFSR_TAPS  = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Gravity step, clamped at terminal velocity; widened to avoid wrap.
  function automatic logic signed [7:0] vel_fall(input logic signed [7:0] v);
    logic signed [8:0] sum;
    sum = $signed({v[7], v}) + $signed({GRAVITY[7], GRAVITY});
    vel_fall = (sum > $signed({VMAX[7], VMAX})) ? VMAX : sum[7:0];
  endfunction

  // Position plus signed velocity, clamped at the top of the screen.
  function automatic logic [15:0] pos_add_vel(input logic [15:0] pos,
                                              input logic signed [7:0] v);
    logic [16:0] sum;
    sum = {1'b0, pos} + {{9{v[7]}}, v};
    pos_add_vel = sum[16] ? 16'd0 : sum[15:0];
  endfunction

endpackage

// File: rtl/flappy_lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11) used to pick pipe gaps.
module flappy_lfsr16
  import flappy_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state
);

  // Advance every clock regardless of game state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_SEED;
    end else begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/flappy_game_sequencer.sv
// Per-frame flappy game sequencer: bird physics, pipe scroll, scoring and the
// IDLE/PLAY/DYING/OVER machine. Define FLAPPY_HISCORE_EN to keep a best score.
module flappy_game_sequencer
  import flappy_pkg::*;
(
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        frame_tick,
  input  logic        press,
  input  logic        collide,
  output logic [15:0] bird_y,
  output logic [15:0] pipe_x,
  output logic [15:0] gap_y,
  output logic [15:0] score,
  output logic [1:0]  game_state,
  output logic        text_on,
  output logic [15:0] hiscore
);

  game_state_t       state_r;
  logic signed [7:0] vel_r;
  logic              press_q_r;
  logic              flap_pend_r;
  logic              hit_r;
  logic [7:0]        lfsr_byte_s;
  logic [7:0]        lfsr_unused_s;

  logic              flap_s, hit_s, wrap_s, scored_s, die_s, landed_s;
  logic signed [7:0] vel_play_s, vel_dy_s;
  logic [15:0]       bird_play_s, bird_dy_raw_s, bird_dy_s;
  logic [15:0]       pipe_next_s, gap_new_s, score_inc_s;

  flappy_lfsr16 u_lfsr (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .state ({lfsr_unused_s, lfsr_byte_s})
  );

  assign game_state = state_r;

  // Next-frame physics, pipe and scoring candidates for PLAY and DYING.
  always_comb begin
    flap_s        = flap_pend_r | (press & ~press_q_r);
    hit_s         = hit_r | collide;
    vel_play_s    = flap_s ? FLAP_VEL : vel_fall(vel_r);
    bird_play_s   = pos_add_vel(bird_y, vel_play_s);
    wrap_s        = (pipe_x < PIPE_SPEED);
    gap_new_s     = GAP_MIN + {8'd0, lfsr_byte_s};
    pipe_next_s   = wrap_s ? PIPE_START : (pipe_x - PIPE_SPEED);
    scored_s      = (pipe_x >= BIRD_X) && (pipe_next_s < BIRD_X);
    score_inc_s   = (score == 16'hFFFF) ? score : (score + 16'd1);
    die_s         = hit_s || (({1'b0, bird_play_s} + {1'b0, BIRD_H}) >= {1'b0, GROUND_Y});
    vel_dy_s      = vel_fall(vel_r);
    bird_dy_raw_s = pos_add_vel(bird_y, vel_dy_s);
    landed_s      = (bird_dy_raw_s >= FLOOR_Y);
    bird_dy_s     = landed_s ? FLOOR_Y : bird_dy_raw_s;
  end

  // Game state machine; everything advances only on frame_tick.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r     <= ST_IDLE;
      bird_y      <= START_Y;
      vel_r       <= 8'sd0;
      pipe_x      <= PIPE_START;
      gap_y       <= GAP_MIN;
      score       <= 16'd0;
      text_on     <= 1'b0;
      press_q_r   <= 1'b0;
      flap_pend_r <= 1'b0;
      hit_r       <= 1'b0;
    end else begin
      press_q_r <= press;
      case (state_r)
        ST_IDLE: begin
          if (frame_tick) begin
            if (flap_s) begin
              state_r     <= ST_PLAY;
              vel_r       <= FLAP_VEL;
              score       <= 16'd0;
              pipe_x      <= PIPE_START;
              gap_y       <= gap_new_s;
              flap_pend_r <= 1'b0;
              hit_r       <= 1'b0;
            end
          end else begin
            flap_pend_r <= flap_s;
          end
        end
        ST_PLAY: begin
          hit_r <= hit_s;
          if (frame_tick) begin
            vel_r       <= vel_play_s;
            bird_y      <= bird_play_s;
            pipe_x      <= pipe_next_s;
            flap_pend_r <= 1'b0;
            if (wrap_s) gap_y <= gap_new_s;
            if (scored_s) score <= score_inc_s;
            if (die_s) state_r <= ST_DYING;
          end else begin
            flap_pend_r <= flap_s;
          end
        end
        ST_DYING: begin
          if (frame_tick) begin
            vel_r  <= vel_dy_s;
            bird_y <= bird_dy_s;
            if (landed_s) begin
              state_r <= ST_OVER;
              text_on <= 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (frame_tick) begin
            if (flap_s) begin
              state_r     <= ST_IDLE;
              bird_y      <= START_Y;
              vel_r       <= 8'sd0;
              text_on     <= 1'b0;
              flap_pend_r <= 1'b0;
            end
          end else begin
            flap_pend_r <= flap_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FLAPPY_HISCORE_EN
  logic [15:0] hiscore_r;

  // Best score latched on OVER entry; only the hard reset clears it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hiscore_r <= 16'd0;
    end else if ((state_r == ST_DYING) && frame_tick && landed_s && (score > hiscore_r)) begin
      hiscore_r <= score;
    end
  end

  assign hiscore = hiscore_r;
`else
  assign hiscore = 16'd0;
`endif

endmodule

// File: doc/flappy_game_sequencer.md
Name: flappy_game_sequencer

Overview:
- Hardware game-state sequencer that replaces the software game loop.
- Once per video frame it advances bird physics and pipe scrolling, detects scoring and death, and runs the IDLE/PLAY/DYING/OVER state machine.
- Outputs feed the same video datapath that consumes bird_y, pipe_x, score and text_on.

Parameters:
- BIRD_X, 160, fixed bird column (px)
- BIRD_H, 24, bird sprite height (px)
- START_Y, 200, bird y in IDLE
- GROUND_Y, 440, ground line (px)
- GRAVITY, 1, velocity increment per frame
- FLAP_VEL, -8, signed velocity loaded on flap
- VMAX, 10, terminal downward velocity
- PIPE_SPEED, 2, px per frame
- PIPE_START, 640, pipe_x reload value
- GAP_MIN, 64, minimum gap top

Ports:
- clk_clk, in, 1, system clock
- reset_reset_n, in, 1, reset
- frame_tick, in, 1, one-cycle pulse per vsync
- press, in, 1, synchronous level, flap key
- collide, in, 1, pixel-overlap flag from video datapath
- bird_y, out, 16, bird top y
- pipe_x, out, 16, pipe left x
- gap_y, out, 16, gap top y
- score, out, 16, binary score
- game_state, out, 2, 0=IDLE 1=PLAY 2=DYING 3=OVER
- text_on, out, 1, "game over" overlay enable
- hiscore, out, 16, best score

Behaviour:
- Reset: reset_reset_n is asynchronous, active-low. On reset: state=IDLE, bird_y=START_Y, vel=0, pipe_x=PIPE_START, gap_y=GAP_MIN, score=0, hiscore=0, text_on=0, lfsr=16'hACE1, flap_pend=0, hit=0.
- Press edge: press_q is registered; edge = press & ~press_q.
  - In PLAY, an edge sets flap_pend. It is consumed at the next frame_tick. Multiple edges within one frame give one flap.
- Collide: in PLAY, collide sets sticky hit. It is acted on at the next frame_tick. hit clears on entry to PLAY.
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every clock in all states.
- State updates happen only on frame_tick; outputs are registered and change the cycle after the tick.
- IDLE:
  - Edge -> PLAY, vel=FLAP_VEL, score=0, pipe_x=PIPE_START, gap_y=GAP_MIN+lfsr[7:0].
- PLAY, per tick, in this order:
  1. vel = flap_pend ? FLAP_VEL : min(vel+GRAVITY, VMAX); flap_pend=0.
  2. ny = bird_y+vel as signed 17-bit. If ny<0, bird_y=0 (ceiling clamp, no death); else bird_y=ny.
  3. If pipe_x < PIPE_SPEED: pipe_x=PIPE_START, gap_y=GAP_MIN+lfsr[7:0] (range 64..319). Else pipe_x -= PIPE_SPEED.
  4. Score: if old pipe_x >= BIRD_X and new pipe_x < BIRD_X, score+1, saturating at 16'hFFFF.
  5. If hit, or ny+BIRD_H >= GROUND_Y: go to DYING. Hit and score on the same tick: the score still counts.
- DYING:
  - Pipes and score frozen; presses ignored.
  - vel = min(vel+GRAVITY, VMAX).
  - bird_y = min(bird_y+vel, GROUND_Y-BIRD_H). Reaching that floor -> OVER.
- OVER:
  - text_on=1. Edge -> IDLE: bird_y=START_Y, vel=0, text_on=0. Score is held until the next PLAY entry.
- frame_tick and press edge in the same cycle: the edge is registered first, so it is consumed by that tick.
- frame_tick held high for multiple cycles: each cycle counts as a tick. This is the caller's responsibility.
- Arithmetic: velocity is 8-bit signed; positions are 16-bit unsigned; all compares are unsigned after the clamp.

Optional Feature:
- Macro: FLAPPY_HISCORE_EN.
- Defined: on OVER entry, hiscore = max(hiscore, score). hiscore is cleared only by reset_reset_n.
- Undefined: hiscore is tied to 0 and no register is inferred.

Decomposition:
- flappy_pkg holds:
  - game_state_t enum (IDLE, PLAY, DYING, OVER)
  - default physics/geometry constants
  - LFSR seed and tap mask
- Sub-module flappy_lfsr16: free-running LFSR with async reset and a 16-bit state output.

Test Plan:
- Reset released, no press, 10 ticks -> state=IDLE, bird_y=200, pipe_x=640, score=0, text_on=0.
- Press edge in IDLE, then 1 tick -> PLAY.
  - Next tick (no press): vel -8 -> -7, bird_y=193.
  - Then 20 ticks: vel saturates at 10.
- PLAY with bird held mid-air by periodic presses, pipe_x=161 -> after tick pipe_x=159, score=1.
  - pipe_x=1 -> reload to 640, gap_y in 64..319.
- collide pulsed for 1 cycle mid-frame -> next tick state=DYING. Pipe_x frozen; bird falls to 416; state=OVER; text_on=1.
- Press storm (5 edges) between two ticks -> exactly one flap, vel=-8.
- Assert reset_reset_n mid-DYING -> all outputs at reset values immediately, without waiting for a clock edge.
  - With FLAPPY_HISCORE_EN, two games scoring 3 then 2 -> hiscore=3.
